// File: rtl/gray_stream_gen_pkg.sv
// Shared video definitions: pattern codes, FSM encodings and the pixel formula.
// Downstream filter blocks import this package for the same codes.
package gray_stream_gen_pkg;

    localparam int CNT_W = 16;
    localparam int DIV_W = 4;
    localparam int PAT_W = 2;

    typedef enum logic [PAT_W-1:0] {
        PAT_HRAMP = 2'd0,
        PAT_VRAMP = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_FLAT  = 2'd3
    } pat_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VPRE   = 3'd1,
        ST_LINE   = 3'd2,
        ST_HBLANK = 3'd3,
        ST_VPOST  = 3'd4
    } state_e;

    function automatic logic [7:0] pix_value(pat_e pat, logic [7:0] x, logic [7:0] y,
                                             logic [7:0] f);
        logic [7:0] v;
        case (pat)
            PAT_HRAMP: v = x;
            PAT_VRAMP: v = y;
            PAT_CHECK: v = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
            default:   v = f;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/gray_stream_gen_if.sv
// Control and video-stream bundle between the gray pattern generator and its sink.
interface gray_stream_gen_if;
    import gray_stream_gen_pkg::*;

    logic             start;
    logic             continuous;
    logic [PAT_W-1:0] pattern_sel;
    logic             pre_frame_vsync;
    logic             pre_frame_hsync;
    logic             pre_frame_clken;
    logic [7:0]       pre_img_Y;
    logic             busy;
    logic             frame_done;

    modport master (
        input  start, continuous, pattern_sel,
        output pre_frame_vsync, pre_frame_hsync, pre_frame_clken, pre_img_Y,
               busy, frame_done
    );

    modport slave (
        output start, continuous, pattern_sel,
        input  pre_frame_vsync, pre_frame_hsync, pre_frame_clken, pre_img_Y,
               busy, frame_done
    );

endinterface

// File: rtl/gray_stream_gen.sv
// Gray test-pattern frame generator: vsync/hsync envelopes, paced pixel strobes
// and a selectable 8-bit pattern, one frame per start or back-to-back.
module gray_stream_gen
    import gray_stream_gen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 160,
    parameter int V_PRE    = 1000,
    parameter int V_POST   = 1000,
    parameter int PIX_DIV  = 1
) (
    input logic               clk,
    input logic               rst,
    gray_stream_gen_if.master bus
);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic [7:0]       f;
    pat_e             pat_q;

    logic             vsync;
    logic             hsync;
    logic             clken;
    logic [7:0]       img_y;
    logic             busy;
    logic             done;

    logic [7:0]       px;
    logic [7:0]       pix;

    // Value of the next strobe: first pixel of a line unless we are mid-line.
    always_comb begin
        px  = (state == ST_LINE) ? x[7:0] + 8'd1 : 8'd0;
        pix = pix_value(pat_q, px, y[7:0], f);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            div   <= '0;
            x     <= '0;
            y     <= '0;
            f     <= '0;
            pat_q <= PAT_HRAMP;
            vsync <= 1'b0;
            hsync <= 1'b0;
            clken <= 1'b0;
            img_y <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            clken <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state <= ST_VPRE;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        x     <= '0;
                        y     <= '0;
                        pat_q <= pat_e'(bus.pattern_sel);
                    end
                end

                ST_VPRE: begin
                    if (cnt == CNT_W'(V_PRE - 1)) begin
                        state <= ST_LINE;
                        cnt   <= '0;
                        div   <= '0;
                        x     <= '0;
                        vsync <= 1'b1;
                        hsync <= 1'b1;
                        clken <= 1'b1;
                        img_y <= pix;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_LINE: begin
                    if (div == DIV_W'(PIX_DIV - 1)) begin
                        div <= '0;
                        if (x == CNT_W'(H_ACTIVE - 1)) begin
                            hsync <= 1'b0;
                            cnt   <= '0;
                            // Last line drops vsync together with hsync, no trailing blank.
                            if (y == CNT_W'(V_ACTIVE - 1)) begin
                                state <= ST_VPOST;
                                vsync <= 1'b0;
                                done  <= (V_POST == 1);
                            end else begin
                                state <= ST_HBLANK;
                                y     <= y + CNT_W'(1);
                            end
                        end else begin
                            x     <= x + CNT_W'(1);
                            clken <= 1'b1;
                            img_y <= pix;
                        end
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end

                ST_HBLANK: begin
                    if (cnt == CNT_W'(H_BLANK - 1)) begin
                        state <= ST_LINE;
                        cnt   <= '0;
                        div   <= '0;
                        x     <= '0;
                        hsync <= 1'b1;
                        clken <= 1'b1;
                        img_y <= pix;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_VPOST: begin
                    if (cnt == CNT_W'(V_POST - 1)) begin
                        f   <= f + 8'd1;
                        cnt <= '0;
                        if (bus.continuous) begin
                            state <= ST_VPRE;
                            x     <= '0;
                            y     <= '0;
                            pat_q <= pat_e'(bus.pattern_sel);
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                        // Registered pulse must land on the final VPOST cycle.
                        done <= (cnt == CNT_W'(V_POST - 2));
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.pre_frame_vsync = vsync;
    assign bus.pre_frame_hsync = hsync;
    assign bus.pre_frame_clken = clken;
    assign bus.pre_img_Y       = img_y;
    assign bus.busy            = busy;
    assign bus.frame_done      = done;

endmodule

// File: tb/tb_gray_stream_gen.sv
// Bench for gray_stream_gen: table of frame scenarios with a Y scoreboard,
// plus hand sequences for reset abort and pixel pacing.
module tb_gray_stream_gen;

    localparam int H_A  = 4;
    localparam int V_A  = 3;
    localparam int H_B  = 2;
    localparam int V_PR = 3;
    localparam int V_PO = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gray_stream_gen_if bus();
    gray_stream_gen_if bus3();

    gray_stream_gen #(.H_ACTIVE(H_A), .V_ACTIVE(V_A), .H_BLANK(H_B), .V_PRE(V_PR),
                      .V_POST(V_PO), .PIX_DIV(1)) dut (.clk(clk), .rst(rst), .bus(bus));

    gray_stream_gen #(.H_ACTIVE(H_A), .V_ACTIVE(V_A), .H_BLANK(H_B), .V_PRE(V_PR),
                      .V_POST(V_PO), .PIX_DIV(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct {
        string      name;
        logic [1:0] pat;
        int         nframes;
        int         chg_cyc;
        logic [1:0] chg_pat;
        int         xstart_cyc;
        bit         abort_first;
        int         vs_rise;
        int         vs_high;
        int         hs_pulses;
        int         strobes;
        int         dones;
        int         first_done;
        int         busy_clr;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    logic [7:0] f_model = 8'd0;
    logic [7:0] sb_q[$];

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_y(input logic [1:0] p, input int x, input int y,
                                         input logic [7:0] f);
        case (p)
            2'd0:    return 8'(x);
            2'd1:    return 8'(y);
            2'd2:    return ((x & 8) != (y & 8)) ? 8'hFF : 8'h00;
            default: return f;
        endcase
    endfunction

    function automatic int outs0();
        return int'({bus.pre_frame_vsync, bus.pre_frame_hsync, bus.pre_frame_clken,
                     bus.busy, bus.frame_done, bus.pre_img_Y});
    endfunction

    function automatic int outs3();
        return int'({bus3.pre_frame_vsync, bus3.pre_frame_hsync, bus3.pre_frame_clken,
                     bus3.busy, bus3.frame_done, bus3.pre_img_Y});
    endfunction

    task automatic run_vec(input vec_t v);
        int cyc = 0, vs_rise = -1, vs_high = 0, hs_pulses = 0, strobes = 0;
        int dones = 0, first_done = -1, busy_clr = -1, viol = 0;
        logic prev_hs = 1'b0, seen_busy = 1'b0;
        logic [1:0] p;
        logic [7:0] fk;
        for (int k = 0; k < v.nframes; k++) begin
            p  = (k == 0 || v.chg_cyc < 0) ? v.pat : v.chg_pat;
            fk = f_model + 8'(k);
            for (int yy = 0; yy < V_A; yy++)
                for (int xx = 0; xx < H_A; xx++)
                    sb_q.push_back(exp_y(p, xx, yy, fk));
        end
        @(posedge clk); #1;
        bus.start       = 1'b1;
        bus.pattern_sel = v.pat;
        bus.continuous  = (v.nframes > 1);
        while (cyc < 300 && busy_clr < 0) begin
            @(negedge clk);
            if (bus.pre_frame_vsync && vs_rise < 0) vs_rise = cyc;
            if (bus.pre_frame_vsync) vs_high++;
            if (bus.pre_frame_hsync && !prev_hs) hs_pulses++;
            prev_hs = bus.pre_frame_hsync;
            if ((bus.pre_frame_clken && !bus.pre_frame_hsync) ||
                (bus.pre_frame_hsync && !bus.pre_frame_vsync)) viol++;
            if (bus.pre_frame_clken) begin
                strobes++;
                if (sb_q.size() == 0) check($sformatf("%s.sb_underflow", v.name), 1, 0);
                else check($sformatf("%s.y", v.name), int'(bus.pre_img_Y), int'(sb_q.pop_front()));
            end
            if (bus.frame_done) begin
                dones++;
                if (first_done < 0) first_done = cyc;
            end
            if (bus.busy) seen_busy = 1'b1;
            else if (seen_busy) busy_clr = cyc;
            @(posedge clk); #1;
            cyc++;
            bus.start = (cyc == v.xstart_cyc);
            if (cyc == v.chg_cyc) bus.pattern_sel = v.chg_pat;
            if (dones == v.nframes - 1) bus.continuous = 1'b0;
        end
        bus.start      = 1'b0;
        bus.continuous = 1'b0;
        check($sformatf("%s.vs_rise", v.name), vs_rise, v.vs_rise);
        check($sformatf("%s.vs_high", v.name), vs_high, v.vs_high);
        check($sformatf("%s.hs_pulses", v.name), hs_pulses, v.hs_pulses);
        check($sformatf("%s.strobes", v.name), strobes, v.strobes);
        check($sformatf("%s.dones", v.name), dones, v.dones);
        check($sformatf("%s.first_done", v.name), first_done, v.first_done);
        check($sformatf("%s.busy_clr", v.name), busy_clr, v.busy_clr);
        check($sformatf("%s.sb_left", v.name), sb_q.size(), 0);
        check($sformatf("%s.envelope", v.name), viol, 0);
        sb_q.delete();
        f_model = f_model + 8'(v.dones);
    endtask

    // Kill a frame during its second line and confirm nothing leaks out.
    task automatic abort_seq();
        int dones = 0, busy_hi = 0;
        @(posedge clk); #1;
        bus.start       = 1'b1;
        bus.pattern_sel = 2'd0;
        bus.continuous  = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort.in_line", int'({bus.pre_frame_vsync, bus.pre_frame_hsync}), 3);
        #2 rst = 1'b1;
        #1 check("abort.outs", outs0(), 0);
        repeat (4) begin
            @(negedge clk);
            if (bus.frame_done) dones++;
        end
        #2 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.busy || bus.frame_done) busy_hi++;
        end
        check("abort.no_done", dones, 0);
        check("abort.stays_idle", busy_hi, 0);
        f_model = 8'd0;
        sb_q.delete();
    endtask

    task automatic pixdiv_seq();
        int cyc = 0, pos = 0, hs_len = 0, line_str = 0, lines = 0, viol = 0, done_cyc = -1;
        logic prev_ck = 1'b0, prev_hs = 1'b0;
        logic [7:0] q3[$];
        for (int yy = 0; yy < V_A; yy++)
            for (int xx = 0; xx < H_A; xx++)
                q3.push_back(exp_y(2'd0, xx, yy, 8'd0));
        @(posedge clk); #1;
        bus3.start       = 1'b1;
        bus3.pattern_sel = 2'd0;
        while (cyc < 200 && done_cyc < 0) begin
            @(negedge clk);
            if (bus3.pre_frame_hsync) begin
                if (!prev_hs) begin
                    pos      = 0;
                    line_str = 0;
                end else begin
                    pos++;
                end
                hs_len = pos + 1;
                if (bus3.pre_frame_clken) begin
                    line_str++;
                    if (pos % 3 != 0) viol++;
                    if (q3.size() == 0) check("pd.sb_underflow", 1, 0);
                    else check("pd.y", int'(bus3.pre_img_Y), int'(q3.pop_front()));
                end
            end else if (prev_hs) begin
                lines++;
                check("pd.hs_len", hs_len, 12);
                check("pd.strobes_line", line_str, 4);
            end
            if (bus3.pre_frame_clken && (prev_ck || !bus3.pre_frame_hsync)) viol++;
            if (bus3.frame_done) done_cyc = cyc;
            prev_hs = bus3.pre_frame_hsync;
            prev_ck = bus3.pre_frame_clken;
            @(posedge clk); #1;
            cyc++;
            bus3.start = 1'b0;
        end
        check("pd.lines", lines, 3);
        check("pd.done_cyc", done_cyc, 45);
        check("pd.pacing", viol, 0);
        check("pd.sb_left", q3.size(), 0);
    endtask

    initial begin
        vec_t vecs[9];
        int   idle_hi = 0;
        vecs[0] = '{"cont3",    2'd3, 3, -1, 2'd0, -1, 1'b0, 4, 48, 9, 36, 3, 21, 64};
        vecs[1] = '{"hramp",    2'd0, 1, -1, 2'd0, -1, 1'b0, 4, 16, 3, 12, 1, 21, 22};
        vecs[2] = '{"vramp",    2'd1, 1, -1, 2'd0, -1, 1'b0, 4, 16, 3, 12, 1, 21, 22};
        vecs[3] = '{"check",    2'd2, 1, -1, 2'd0, -1, 1'b0, 4, 16, 3, 12, 1, 21, 22};
        vecs[4] = '{"flat",     2'd3, 1, -1, 2'd0, -1, 1'b0, 4, 16, 3, 12, 1, 21, 22};
        vecs[5] = '{"latch",    2'd1, 2, 12, 2'd2, -1, 1'b0, 4, 32, 6, 24, 2, 21, 43};
        vecs[6] = '{"ign_start",2'd0, 1, -1, 2'd0,  8, 1'b0, 4, 16, 3, 12, 1, 21, 22};
        vecs[7] = '{"post_rst", 2'd1, 1, -1, 2'd0, -1, 1'b1, 4, 16, 3, 12, 1, 21, 22};
        vecs[8] = '{"flat_rst", 2'd3, 1, -1, 2'd0, -1, 1'b0, 4, 16, 3, 12, 1, 21, 22};

        bus.start        = 1'b0;
        bus.continuous   = 1'b0;
        bus.pattern_sel  = 2'd0;
        bus3.start       = 1'b0;
        bus3.continuous  = 1'b0;
        bus3.pattern_sel = 2'd0;

        #1;
        check("rst.outs", outs0(), 0);
        check("rst.outs3", outs3(), 0);
        #20 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy || bus3.busy) idle_hi++;
        end
        check("rst.idle", idle_hi, 0);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].abort_first) abort_seq();
            run_vec(vecs[i]);
        end
        pixdiv_seq();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
